// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants: instruction width, NOP/HALT encodings
// and the instruction-fetch state encoding.
package mips_pkg;

   localparam int unsigned INSTR_WIDTH = 32;

   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IF_LOAD   = 2'b00,
      IF_RUN    = 2'b01,
      IF_HALTED = 2'b10
   } if_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// No reset on the array, so program contents survive a core reset.
module instruction_memory
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic                         i_clk,
   input  logic                         i_we,
   input  logic [$clog2(DEPTH)-1:0]     i_waddr,
   input  logic [INSTR_WIDTH-1:0]       i_wdata,
   input  logic [$clog2(DEPTH)-1:0]     i_raddr,
   output logic [INSTR_WIDTH-1:0]       o_rdata
);

   logic [INSTR_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, instruction memory, IF/ID register and LOAD/RUN/HALTED control.
// Define IF_JUMP_FLUSH_EN to squash the delay slot on a taken jump (NOP into IF/ID).
module instruction_fetch
   import mips_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 256,
   parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_start,
   input  logic                          i_load_we,
   input  logic [$clog2(MEM_DEPTH)-1:0]  i_load_addr,
   input  logic [INSTR_WIDTH-1:0]        i_load_data,
   input  logic                          i_stall,
   input  logic                          i_jump,
   input  logic [31:0]                   i_jump_address,
   input  logic                          i_halt,
   output logic [INSTR_WIDTH-1:0]        o_instruction,
   output logic [31:0]                   o_pc,
   output logic [1:0]                    o_state
);

   localparam int unsigned AW = $clog2(MEM_DEPTH);

   if_state_t              state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [31:0]            pc_out_q, pc_out_d;

   logic [INSTR_WIDTH-1:0] rd_data;
   logic [31:0]            pc_plus4;
   logic                   mem_we;

   assign pc_plus4 = pc_q + 32'd4;
   assign mem_we   = i_load_we && (state_q == IF_LOAD);

   instruction_memory #(
      .DEPTH (MEM_DEPTH)
   ) u_imem (
      .i_clk   (i_clk),
      .i_we    (mem_we),
      .i_waddr (i_load_addr),
      .i_wdata (i_load_data),
      .i_raddr (pc_q[AW+1:2]),
      .o_rdata (rd_data)
   );

   // Next-state: stall > halt > jump > sequential fetch while running
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      case (state_q)
         IF_LOAD: begin
            pc_d     = PC_RESET;
            instr_d  = NOP_INSTR;
            pc_out_d = 32'd0;
            if (i_start) begin
               state_d = IF_RUN;
            end
         end
         IF_RUN: begin
            if (i_stall) begin
               // decode re-evaluates the jump with held inputs
            end else if (i_halt) begin
               state_d = IF_HALTED;
            end else if (i_jump) begin
               pc_d = i_jump_address;
`ifdef IF_JUMP_FLUSH_EN
               instr_d  = NOP_INSTR;
               pc_out_d = 32'd0;
`else
               instr_d  = rd_data;
               pc_out_d = pc_plus4;
`endif
            end else begin
               pc_d     = pc_plus4;
               instr_d  = rd_data;
               pc_out_d = pc_plus4;
            end
         end
         IF_HALTED: begin
         end
         default: begin
            state_d = IF_LOAD;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IF_LOAD;
         pc_q     <= PC_RESET;
         instr_q  <= NOP_INSTR;
         pc_out_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
      end
   end

   assign o_instruction = instr_q;
   assign o_pc          = pc_out_q;
   assign o_state       = 2'(state_q);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front pipeline stage of the MIPS core: owns the program counter, the instruction memory and the IF/ID pipeline register, and produces the `i_instruction` / `i_pc` pair consumed by instruction decode. It accepts jump redirects, stall requests and halt from decode. It also exposes a load port through which the debug unit writes the program before execution starts.

## Interface
- `MEM_DEPTH`, 256: instruction memory depth in 32-bit words (power of two).
- `PC_RESET`, 32'h0000_0000: PC value after reset.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset, synchronous, active-high; clock `i_clk`.
- `i_start`  in  1  leave LOAD state, begin fetching.
- `i_load_we`  in  1  program write enable (honoured only in LOAD).
- `i_load_addr`  in  log2(MEM_DEPTH)  word address of program write.
- `i_load_data`  in  32  instruction word to write.
- `i_stall`  in  1  hazard stall from hazard detection; holds PC and IF/ID.
- `i_jump`  in  1  redirect request from decode (combinational there).
- `i_jump_address`  in  32  redirect target, byte address.
- `i_halt`  in  1  halt instruction present in decode.
- `o_instruction`  out  32  IF/ID instruction register.
- `o_pc`  out  32  IF/ID PC register, holding fetch address + 4.
- `o_state`  out  2  00 LOAD, 01 RUN, 10 HALTED.

## Operation
- States:
  - LOAD → RUN on `i_start`.
  - RUN → HALTED on `i_halt`.
  - HALTED is left only by reset.
- LOAD:
  - `mem[i_load_addr] <= i_load_data` when `i_load_we`.
  - PC held at `PC_RESET`; `o_instruction` = NOP (0), `o_pc` = 0.
- RUN, each cycle, priority highest first:
  - `i_stall`: PC, `o_instruction` and `o_pc` all hold. `i_jump` is ignored, because decode re-evaluates it with held inputs.
  - `i_halt`: PC, `o_instruction` and `o_pc` all hold, so the HALT word (32'hFFFF_FFFF) stays in decode; state → HALTED.
  - `i_jump`: `PC <= i_jump_address`; `o_instruction <= mem[PC]` (delay slot); `o_pc <= PC+4`.
  - Otherwise: `o_instruction <= mem[PC]`; `o_pc <= PC+4`; `PC <= PC+4`.
- Memory address is `PC[log2(MEM_DEPTH)+1:2]`. PC bits above that range are ignored, so fetch wraps modulo `MEM_DEPTH`. PC[1:0] is ignored.
- Load writes outside LOAD are dropped.
- Memory contents survive reset, so a loaded program can be re-run by reset followed by `i_start`.

## Timing
- Memory read is asynchronous; the only registered outputs are `o_instruction`, `o_pc` and `o_state`.
- Reset values: PC = `PC_RESET`, `o_instruction` = 0, `o_pc` = 0, `o_state` = LOAD.
- Fetch latency: the first instruction appears on `o_instruction` 2 edges after `i_start` is sampled (the `i_start` edge, then the first fetch edge).
- Redirect: the target instruction reaches `o_instruction` on the second edge after `i_jump`. The edge in between delivers the delay slot.
- Simultaneous events:
  - `i_start` together with `i_load_we`: the write completes and the state moves to RUN on the same edge.
  - `i_reset` overrides every other input.
  - `i_halt` with `i_jump` (not architecturally possible): halt wins.

## Configuration
- `IF_JUMP_FLUSH_EN` defined: on a taken `i_jump` in RUN, `o_instruction <= 0` (NOP) and `o_pc <= 0` instead of loading the delay slot. This gives no-delay-slot semantics.
- `IF_JUMP_FLUSH_EN` undefined: delay-slot behaviour as above.

## Structure
- Shared package `mips_pkg`:
  - `NOP_INSTR` (32'h0) and `HALT_INSTR` (32'hFFFF_FFFF).
  - `if_state_t` (LOAD/RUN/HALTED).
  - `INSTR_WIDTH` = 32.
- Sub-module `instruction_memory`: one write port, one asynchronous read port, parameterised by depth.
- PC register, state machine and IF/ID register live in `instruction_fetch`.

## Test plan
- Sequential fetch: load words 0x11,0x22,0x33 at addresses 0..2, then pulse `i_start` → `o_instruction` sequence 0x11,0x22,0x33 with `o_pc` 4,8,12.
- Stall: assert `i_stall` for 2 cycles while `o_instruction`=0x22 → 0x22 / `o_pc`=8 held for 2 cycles, then 0x33 / 12.
- Jump: `i_jump`=1 with `i_jump_address`=0x40 while PC=8 → next `o_instruction`=mem[2] (with `IF_JUMP_FLUSH_EN`: 0), then mem[16] with `o_pc`=0x44.
- Stall with jump in the same cycle → PC unchanged; the jump is taken only on the first unstalled cycle.
- Halt: `i_halt` raised with HALT in IF/ID → `o_state`=10, `o_instruction` stays 0xFFFF_FFFF and the PC is frozen for 10+ cycles.
- Reset mid-RUN, then `i_start` without reloading → fetch restarts from 0x11 with `o_pc`=4; program memory is unchanged; a load write during RUN does not modify memory.
